// File: rtl/l1_mem_ctrl.sv
// l1_mem_ctrl: L1 miss sequencer, optional dirty-victim writeback followed by a line fill from mainmemory.
// Latency: fill_valid 4 cycles after accept without writeback, 8 with writeback, for a 2-cycle memory.
// Backpressure: req_ready only in IDLE, so one miss is in flight at a time; each memory wait is bounded by TIMEOUT_CYC.
module l1_mem_ctrl #(
    parameter int MEM_ENTRIES = 256,
    parameter int TIMEOUT_CYC = 15
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         req_valid,
    output logic         req_ready,
    input  logic [26:0]  req_fill_addr,
    input  logic         req_wb,
    input  logic [26:0]  req_wb_addr,
    input  logic [255:0] req_wb_data,
    input  logic [31:0]  req_wb_be,
    output logic         fill_valid,
    output logic [255:0] fill_data,
    output logic         err,
    output logic [1:0]   err_code,
    output logic [26:0]  mem_a,
    output logic [31:0]  mem_be,
    output logic [255:0] mem_wd,
    output logic         mem_write,
    output logic         mem_read,
    input  logic [255:0] mem_rd,
    input  logic         mem_valid,
    input  logic         mem_ready
);
    localparam int            CW         = $clog2(TIMEOUT_CYC + 1);
    localparam logic [27:0]   ADDR_LIMIT = 28'(MEM_ENTRIES);
    localparam logic [CW-1:0] TMO_LAST   = CW'(TIMEOUT_CYC - 1);

    typedef enum logic [2:0] {
        IDLE, WB_SETUP, WB_ISSUE, WB_WAIT, FILL_ISSUE, FILL_WAIT, RESP
    } state_t;

    state_t          state_q, state_d;
    logic [26:0]     fill_addr_q;
    logic [CW-1:0]   tmo_cnt_q;
    logic            accept, wb_bad, fill_bad, in_wait, tmo_last, tmo_err;

    assign accept   = req_valid && (state_q == IDLE);
    assign wb_bad   = req_wb && ({1'b0, req_wb_addr} >= ADDR_LIMIT);
    assign fill_bad = {1'b0, req_fill_addr} >= ADDR_LIMIT;
    assign in_wait  = (state_q == WB_WAIT) || (state_q == FILL_WAIT);
    assign tmo_last = (tmo_cnt_q == TMO_LAST);

    assign req_ready  = (state_q == IDLE);
    assign mem_write  = (state_q == WB_ISSUE);
    assign mem_read   = (state_q == FILL_ISSUE);
    assign fill_valid = (state_q == RESP);

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        tmo_err = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept && !wb_bad && !fill_bad) state_d = req_wb ? WB_SETUP : FILL_ISSUE;
            end
            WB_SETUP: state_d = WB_ISSUE;
            WB_ISSUE: state_d = WB_WAIT;
            WB_WAIT: begin
                if (mem_ready) begin
                    state_d = FILL_ISSUE;
                end else if (tmo_last) begin
                    state_d = IDLE;
                    tmo_err = 1'b1;
                end
            end
            FILL_ISSUE: state_d = FILL_WAIT;
            FILL_WAIT: begin
                if (mem_valid) begin
                    state_d = RESP;
                end else if (tmo_last) begin
                    state_d = IDLE;
                    tmo_err = 1'b1;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Counter restarts whenever a wait state is entered or left.
    always_ff @(posedge clk) begin
        if (rst)                              tmo_cnt_q <= '0;
        else if (in_wait && state_d == state_q) tmo_cnt_q <= tmo_cnt_q + 1'b1;
        else                                  tmo_cnt_q <= '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fill_addr_q <= '0;
            fill_data   <= '0;
            err         <= 1'b0;
            err_code    <= 2'b00;
            mem_a       <= '0;
            mem_be      <= '0;
            mem_wd      <= '0;
        end else begin
            err <= 1'b0;
            if (accept) begin
                fill_addr_q <= req_fill_addr;
                if (wb_bad) begin
                    err      <= 1'b1;
                    err_code <= 2'b01;
                end else if (fill_bad) begin
                    err      <= 1'b1;
                    err_code <= 2'b10;
                end else if (req_wb) begin
                    // Address must sit on the bus a full cycle before the write strobe.
                    mem_a  <= req_wb_addr;
                    mem_wd <= req_wb_data;
                    mem_be <= req_wb_be;
                end else begin
                    mem_a <= req_fill_addr;
                end
            end
            if (state_q == WB_WAIT && mem_ready) mem_a <= fill_addr_q;
            if (state_q == FILL_WAIT && mem_valid) fill_data <= mem_rd;
            if (tmo_err) begin
                err      <= 1'b1;
                err_code <= 2'b11;
            end
        end
    end
endmodule

// File: tb/tb_l1_mem_ctrl.sv
// Bench for l1_mem_ctrl: per-cycle expectation timeline built from each request's
// transaction rules, a delay-programmable memory stub, and a few literal pins.
module tb_l1_mem_ctrl;
    localparam int MEM_ENTRIES = 256;
    localparam int T           = 15;
    localparam int MAXC        = 16384;

    logic         clk = 1'b0;
    logic         rst;
    logic         req_valid, req_ready, req_wb;
    logic [26:0]  req_fill_addr, req_wb_addr;
    logic [255:0] req_wb_data;
    logic [31:0]  req_wb_be;
    logic         fill_valid, err, mem_write, mem_read, mem_valid, mem_ready;
    logic [255:0] fill_data, mem_wd, mem_rd;
    logic [1:0]   err_code;
    logic [26:0]  mem_a;
    logic [31:0]  mem_be;

    int cyc = 0;
    int checks = 0;
    int failures = 0;
    int busy_until = 0;
    bit chk_en = 1'b0;
    int wdelay = 2;
    int rdelay = 2;
    int n_rd = 0, n_wr = 0, n_fv = 0, n_err = 0;
    int last_fv = -1, last_wr = -1, last_err = -1;

    bit           exp_rdy [MAXC];
    bit           exp_rd [MAXC];
    bit           exp_wr [MAXC];
    bit           exp_fv [MAXC];
    bit           exp_err [MAXC];
    logic [1:0]   exp_code [MAXC];
    logic [255:0] exp_fd [MAXC];
    bit           exp_a_vld [MAXC];
    logic [26:0]  exp_a [MAXC];
    bit           exp_w_vld [MAXC];
    logic [255:0] exp_wd [MAXC];
    logic [31:0]  exp_be [MAXC];
    bit           stub_v [MAXC];
    bit           stub_r [MAXC];
    bit           spur [MAXC];
    logic [255:0] stub_rdata [MAXC];
    logic [255:0] model_mem [MEM_ENTRIES];
    logic [255:0] stub_mem [MEM_ENTRIES];

    l1_mem_ctrl #(.MEM_ENTRIES(MEM_ENTRIES), .TIMEOUT_CYC(T)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_fill_addr(req_fill_addr), .req_wb(req_wb), .req_wb_addr(req_wb_addr),
        .req_wb_data(req_wb_data), .req_wb_be(req_wb_be),
        .fill_valid(fill_valid), .fill_data(fill_data),
        .err(err), .err_code(err_code),
        .mem_a(mem_a), .mem_be(mem_be), .mem_wd(mem_wd),
        .mem_write(mem_write), .mem_read(mem_read),
        .mem_rd(mem_rd), .mem_valid(mem_valid), .mem_ready(mem_ready)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [255:0] merge(input logic [255:0] old, input logic [255:0] nw,
                                           input logic [31:0] be);
        logic [255:0] r;
        r = old;
        for (int b = 0; b < 32; b++) if (be[b]) r[b*8 +: 8] = nw[b*8 +: 8];
        return r;
    endfunction

    function automatic logic [26:0] gen_addr();
        int r;
        r = $urandom_range(0, 19);
        if (r == 0) return 27'($urandom);
        if (r == 1) return 27'd256;
        if (r == 2) return 27'd255;
        return 27'($urandom_range(0, MEM_ENTRIES - 1));
    endfunction

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", name, cyc, act, exp);
        end
    endtask

    // Memory stub: answers a strobe after the programmed delay (0 = never).
    always @(negedge clk) begin
        if (cyc < MAXC - 64) begin
            if (mem_write) begin
                n_wr++;
                last_wr = cyc;
                if (mem_a < 27'(MEM_ENTRIES)) stub_mem[int'(mem_a)] = merge(stub_mem[int'(mem_a)], mem_wd, mem_be);
                if (wdelay > 0) stub_r[cyc + wdelay] = 1'b1;
            end
            if (mem_read) begin
                n_rd++;
                if (rdelay > 0) begin
                    stub_v[cyc + rdelay]     = 1'b1;
                    stub_rdata[cyc + rdelay] = (mem_a < 27'(MEM_ENTRIES)) ? stub_mem[int'(mem_a)] : '0;
                end
            end
            mem_valid = stub_v[cyc] | spur[cyc];
            mem_ready = stub_r[cyc] | spur[cyc];
            mem_rd    = stub_v[cyc] ? stub_rdata[cyc] : {8{$urandom}};
        end
    end

    always @(negedge clk) begin
        if (fill_valid) begin n_fv++; last_fv = cyc; end
        if (err) begin n_err++; last_err = cyc; end
    end

    // Compare process: every cycle once out of reset.
    always @(negedge clk) begin
        if (chk_en && cyc < MAXC) begin
            chk("req_ready", 256'(req_ready), 256'(exp_rdy[cyc]));
            chk("mem_read", 256'(mem_read), 256'(exp_rd[cyc]));
            chk("mem_write", 256'(mem_write), 256'(exp_wr[cyc]));
            chk("fill_valid", 256'(fill_valid), 256'(exp_fv[cyc]));
            chk("err", 256'(err), 256'(exp_err[cyc]));
            if (exp_fv[cyc]) chk("fill_data", fill_data, exp_fd[cyc]);
            if (exp_err[cyc]) chk("err_code", 256'(err_code), 256'(exp_code[cyc]));
            if (exp_a_vld[cyc]) chk("mem_a", 256'(mem_a), 256'(exp_a[cyc]));
            if (exp_w_vld[cyc]) begin
                chk("mem_wd", mem_wd, exp_wd[cyc]);
                chk("mem_be", 256'(mem_be), 256'(exp_be[cyc]));
            end
        end
    end

    // dw/dr: memory response delay in cycles, 0 = never answers. rst_off: pulse rst that many cycles after accept.
    task automatic run_txn(input bit wb, input logic [26:0] wa, input logic [255:0] wd,
                           input logic [31:0] be, input logic [26:0] fa, input int dw, input int dr,
                           input int rst_off, input bit spur_after, input int gap, output int c0);
        int t, e, hi;
        while (cyc < busy_until) @(negedge clk);
        repeat (gap) @(negedge clk);
        c0 = cyc;
        req_valid = 1'b1; req_wb = wb; req_wb_addr = wa; req_wb_data = wd;
        req_wb_be = be; req_fill_addr = fa;
        wdelay = dw; rdelay = dr;
        e = c0 + 1;
        if (wb && wa >= 27'(MEM_ENTRIES)) begin
            exp_err[e] = 1'b1; exp_code[e] = 2'b01;
        end else if (fa >= 27'(MEM_ENTRIES)) begin
            exp_err[e] = 1'b1; exp_code[e] = 2'b10;
        end else begin
            t = c0 + 1;
            if (wb) begin
                model_mem[int'(wa)] = merge(model_mem[int'(wa)], wd, be);
                exp_wr[t + 1] = 1'b1;
                hi = (dw == 0) ? t + 1 + T : t + 1 + dw;
                for (int k = t; k <= hi; k++) begin
                    exp_a_vld[k] = 1'b1; exp_a[k] = wa;
                    exp_w_vld[k] = 1'b1; exp_wd[k] = wd; exp_be[k] = be;
                end
                if (dw == 0) begin
                    e = t + 2 + T; exp_err[e] = 1'b1; exp_code[e] = 2'b11;
                end
                t = t + 2 + dw;
            end
            if (!(wb && dw == 0)) begin
                exp_rd[t] = 1'b1;
                hi = (dr == 0) ? t + T : t + dr;
                for (int k = t; k <= hi; k++) begin
                    exp_a_vld[k] = 1'b1; exp_a[k] = fa;
                end
                if (dr == 0) begin
                    e = t + 1 + T; exp_err[e] = 1'b1; exp_code[e] = 2'b11;
                end else begin
                    exp_fv[t + dr + 1] = 1'b1; exp_fd[t + dr + 1] = model_mem[int'(fa)];
                    e = t + dr + 2;
                end
            end
        end
        for (int k = c0 + 1; k < e; k++) exp_rdy[k] = 1'b0;
        busy_until = e;
        if (spur_after) spur[e + 1] = 1'b1;
        @(negedge clk);
        while (cyc < e) begin
            req_valid = 1'($urandom); req_wb = 1'($urandom);
            req_wb_addr = 27'($urandom); req_fill_addr = 27'($urandom);
            req_wb_data = {8{$urandom}}; req_wb_be = $urandom;
            if (rst_off != 0 && cyc == c0 + rst_off) begin
                rst = 1'b1;
                req_valid = 1'b0;
                for (int k = cyc + 1; k <= e; k++) begin
                    exp_rdy[k] = 1'b1; exp_rd[k] = 1'b0; exp_wr[k] = 1'b0; exp_fv[k] = 1'b0;
                    exp_err[k] = 1'b0; exp_a_vld[k] = 1'b0; exp_w_vld[k] = 1'b0;
                end
                e = cyc + 1;
                busy_until = e;
            end
            @(negedge clk);
            rst = 1'b0;
        end
        req_valid = 1'b0;
    endtask

    initial begin
        #(MAXC * 10);
        failures++;
        $display("FAIL watchdog cyc=%0d got=running exp=finished", cyc);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    initial begin
        int c0, rd0, wr0, fv0, err0;
        bit wb;
        logic [26:0] wa, fa;
        int dw, dr;
        rst = 1'b1; req_valid = 1'b0; req_wb = 1'b0; req_wb_addr = '0; req_fill_addr = '0;
        req_wb_data = '0; req_wb_be = '0;
        for (int i = 0; i < MAXC; i++) exp_rdy[i] = 1'b1;
        for (int i = 0; i < MEM_ENTRIES; i++) begin
            model_mem[i] = {8{$urandom}};
            stub_mem[i]  = model_mem[i];
        end
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk_en = 1'b1;
        busy_until = cyc;
        chk("rst_req_ready", 256'(req_ready), 256'(1));
        chk("rst_fill_data", fill_data, '0);
        chk("rst_err_code", 256'(err_code), '0);
        chk("rst_mem_a", 256'(mem_a), '0);
        chk("rst_mem_wd_be", mem_wd | 256'(mem_be), '0);
        chk("rst_strobes", 256'({mem_read, mem_write, fill_valid, err}), '0);

        // Clean miss
        model_mem[5] = {32{8'hA5}}; stub_mem[5] = {32{8'hA5}};
        rd0 = n_rd;
        run_txn(1'b0, 27'd0, '0, '0, 27'd5, 2, 2, 0, 1'b0, 1, c0);
        @(negedge clk);
        chk("clean_fv_cycle", 256'(last_fv - c0), 256'(4));
        chk("clean_fill_data", fill_data, {32{8'hA5}});
        chk("clean_one_read", 256'(n_rd - rd0), 256'(1));

        // Dirty miss, then read the victim back
        run_txn(1'b1, 27'd3, {32{8'h11}}, 32'hFFFF_FFFF, 27'd7, 2, 2, 0, 1'b0, 0, c0);
        @(negedge clk);
        chk("dirty_wr_cycle", 256'(last_wr - c0), 256'(2));
        chk("dirty_fv_cycle", 256'(last_fv - c0), 256'(8));
        run_txn(1'b0, 27'd0, '0, '0, 27'd3, 2, 2, 0, 1'b0, 0, c0);
        @(negedge clk);
        chk("victim_readback", fill_data, {32{8'h11}});

        // Same address writeback and fill
        run_txn(1'b1, 27'd9, {16{16'hDEAD}}, 32'hFFFF_FFFF, 27'd9, 2, 2, 0, 1'b0, 0, c0);
        @(negedge clk);
        chk("same_addr_data", fill_data, {16{16'hDEAD}});

        // Range errors
        rd0 = n_rd; wr0 = n_wr;
        run_txn(1'b0, 27'd0, '0, '0, 27'd256, 2, 2, 0, 1'b1, 0, c0);
        @(negedge clk);
        chk("fill_range_err_cycle", 256'(last_err - c0), 256'(1));
        chk("fill_range_code", 256'(err_code), 256'(2'b10));
        chk("fill_range_no_read", 256'(n_rd - rd0), '0);
        run_txn(1'b1, 27'd300, {8{$urandom}}, '1, 27'd1, 2, 2, 0, 1'b1, 0, c0);
        @(negedge clk);
        chk("wb_range_code", 256'(err_code), 256'(2'b01));
        chk("wb_range_no_write", 256'(n_wr - wr0), '0);

        // Fill timeout with a late mem_valid afterwards
        fv0 = n_fv;
        run_txn(1'b0, 27'd0, '0, '0, 27'd10, 2, 0, 0, 1'b1, 0, c0);
        repeat (3) @(negedge clk);
        chk("fill_tmo_cycle", 256'(last_err - c0), 256'(17));
        chk("fill_tmo_code", 256'(err_code), 256'(2'b11));
        chk("fill_tmo_no_fv", 256'(n_fv - fv0), '0);

        // Writeback timeout
        run_txn(1'b1, 27'd4, {8{$urandom}}, $urandom, 27'd5, 0, 2, 0, 1'b0, 0, c0);
        @(negedge clk);
        chk("wb_tmo_cycle", 256'(last_err - c0), 256'(18));

        // mem_valid on the last permitted wait cycle
        run_txn(1'b0, 27'd0, '0, '0, 27'd6, 2, T, 0, 1'b0, 0, c0);
        @(negedge clk);
        chk("late_valid_fv_cycle", 256'(last_fv - c0), 256'(17));

        // Reset while in FILL_WAIT, then a normal request
        fv0 = n_fv; err0 = n_err;
        run_txn(1'b0, 27'd0, '0, '0, 27'd11, 2, 0, 3, 1'b0, 0, c0);
        chk("rst_mid_mem_a", 256'(mem_a), '0);
        repeat (2) @(negedge clk);
        chk("rst_mid_no_fv_err", 256'((n_fv - fv0) + (n_err - err0)), '0);
        run_txn(1'b0, 27'd0, '0, '0, 27'd12, 2, 2, 0, 1'b0, 0, c0);
        @(negedge clk);
        chk("after_rst_fv_cycle", 256'(last_fv - c0), 256'(4));

        // Randomized traffic
        for (int n = 0; n < 250 && cyc < MAXC - 200; n++) begin
            wb = 1'($urandom);
            wa = gen_addr();
            fa = (wb && $urandom_range(0, 5) == 0) ? wa : gen_addr();
            dw = ($urandom_range(0, 15) == 0) ? 0 : $urandom_range(1, T);
            dr = ($urandom_range(0, 15) == 0) ? 0 : $urandom_range(1, T);
            run_txn(wb, wa, {8{$urandom}}, ($urandom_range(0, 2) == 0) ? 32'hFFFF_FFFF : $urandom,
                    fa, dw, dr, 0, ($urandom_range(0, 3) == 0), $urandom_range(0, 2), c0);
        end
        while (cyc < busy_until + 3) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
